// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops with a registered result and flags, plus an optional
// iterative shift-and-add multiplier enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);

  localparam int M = WIDTH - 1;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;

  assign w_accept = in_valid && in_ready;

  // Borrow/carry comes out of the extra top bit of a WIDTH+1 wide add or subtract.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (op)
      4'b0000: w_res = a;
      4'b0001: w_res = ~a;
      4'b0010: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
      end
      4'b0011: begin
        w_sum = {1'b0, a} - {1'b0, b};
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[M] != b[M]) && (w_sum[M] != a[M]);
      end
      4'b0100: w_res = a & b;
      4'b0101: w_res = a | b;
      4'b0110: begin
        w_sum = {(WIDTH+1){1'b0}} - {1'b0, a};
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = a[M] && w_sum[M];
      end
      4'b0111: begin
        w_sum = {(WIDTH+1){1'b0}} - {1'b0, b};
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = b[M] && w_sum[M];
      end
      4'b1000: w_res = a ^ b;
      4'b1001: begin
        w_res = {a[M-1:0], 1'b0};
        w_c   = a[M];
      end
      4'b1010: begin
        w_res = {1'b0, a[M:1]};
        w_c   = a[0];
      end
      4'b1011: begin
        w_res = {a[M], a[M:1]};
        w_c   = a[0];
      end
      4'b1100: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry};
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
      end
`ifdef ALU_SEQ_MUL_EN
      4'b1101: w_ill = 1'b0;
`endif
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mul_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // in_ready is taken from state only, so next-state uses in_valid directly to avoid a loop.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (op == 4'b1101)) w_state_next = S_MUL;
      end
      S_MUL: if (w_mul_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept && (op == 4'b1101)) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[M:1]};
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  // Result/flag registers hold between results; illegal ops force a clean zero result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      if ((r_state == S_MUL) && w_mul_last) begin
        y         <= w_acc_next[M:0];
        zero      <= (w_acc_next[M:0] == '0);
        neg       <= w_acc_next[M];
        carry     <= |w_acc_next[2*WIDTH-1:WIDTH];
        ovf       <= 1'b0;
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end
      if (w_accept && (op != 4'b1101)) begin
`else
      if (w_accept) begin
`endif
        y         <= w_ill ? '0 : w_res;
        zero      <= w_ill ? 1'b1 : (w_res == '0);
        neg       <= w_ill ? 1'b0 : w_res[M];
        carry     <= w_ill ? 1'b0 : w_c;
        ovf       <= w_ill ? 1'b0 : w_v;
        illegal   <= w_ill;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus random single-cycle traffic
// against an arithmetic reference model; MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

   localparam int W = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         inValid;
   logic         inReady;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] y;
   logic         outValid, zero, carry, neg, ovf, illegal;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] eY;
   logic         eZero, eCarry, eNeg, eOvf, eIll, eOutValid;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
      .op(op), .a(a), .b(b), .y(y), .out_valid(outValid),
      .zero(zero), .carry(carry), .neg(neg), .ovf(ovf), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int toSigned(input int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   // Reference model built from the op definitions using plain integer arithmetic.
   task automatic refModel(input logic [3:0] o, input int ua, input int ub, input int cin,
                           output int r, output bit c, output bit v, output bit ill);
      int sa, sb, sv, s;
      sa = toSigned(ua); sb = toSigned(ub);
      r = 0; c = 0; v = 0; ill = 0; sv = 0;
      case (o)
         4'd0:  r = ua;
         4'd1:  r = (~ua) & MASK;
         4'd2:  begin s = ua + ub; r = s & MASK; c = (s > MASK); sv = sa + sb; end
         4'd3:  begin r = (ua - ub) & MASK; c = (ua < ub); sv = sa - sb; end
         4'd4:  r = ua & ub;
         4'd5:  r = ua | ub;
         4'd6:  begin r = (-ua) & MASK; c = (ua != 0); sv = -sa; end
         4'd7:  begin r = (-ub) & MASK; c = (ub != 0); sv = -sb; end
         4'd8:  r = ua ^ ub;
         4'd9:  begin r = (ua * 2) & MASK; c = (ua >= (1 << (W - 1))); end
         4'd10: begin r = ua / 2; c = ua % 2; end
         4'd11: begin r = (sa >>> 1) & MASK; c = ua % 2; end
         4'd12: begin s = ua + ub + cin; r = s & MASK; c = (s > MASK); sv = sa + sb + cin; end
`ifdef ALU_SEQ_MUL_EN
         4'd13: begin s = ua * ub; r = s & MASK; c = (s > MASK); end
`endif
         default: ill = 1;
      endcase
      if (o inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd12})
         v = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
   endtask

   task automatic setExpected(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
      int r; bit c, v, ill;
      refModel(o, int'(x), int'(z), int'(eCarry), r, c, v, ill);
      eY = ill ? '0 : W'(r);
      eZero = ill ? 1'b1 : (r == 0);
      eNeg = ill ? 1'b0 : ((r >> (W - 1)) != 0);
      eCarry = ill ? 1'b0 : c;
      eOvf = ill ? 1'b0 : v;
      eIll = ill;
      eOutValid = 1'b1;
   endtask

   task automatic clearExpected();
      eY = '0; eZero = 0; eCarry = 0; eNeg = 0; eOvf = 0; eIll = 0; eOutValid = 0;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".y"}, 32'(y), 32'(eY));
      checkOutput({tag, ".out_valid"}, 32'(outValid), 32'(eOutValid));
      checkOutput({tag, ".zero"}, 32'(zero), 32'(eZero));
      checkOutput({tag, ".carry"}, 32'(carry), 32'(eCarry));
      checkOutput({tag, ".neg"}, 32'(neg), 32'(eNeg));
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(eOvf));
      checkOutput({tag, ".illegal"}, 32'(illegal), 32'(eIll));
      checkOutput({tag, ".in_ready"}, 32'(inReady), 32'd1);
   endtask

   // Drives one cycle from a falling edge, updates the model at the rising edge,
   // and returns on the next falling edge where outputs are stable.
   task automatic applyStimulus(input logic v, input logic [3:0] o,
                                input logic [W-1:0] x, input logic [W-1:0] z);
      inValid = v; op = o; a = x; b = z;
      @(posedge clk);
      if (v) setExpected(o, x, z);
      else eOutValid = 1'b0;
      @(negedge clk);
      inValid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; inValid = 1'b0; op = '0; a = '0; b = '0;
      clearExpected();
      #1;
      checkAll("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      applyStimulus(1, 4'b0010, 8'hFF, 8'h01);
      checkAll("add_wrap");
      checkOutput("add_wrap.y_const", 32'(y), 32'h00);
      applyStimulus(0, 4'b0000, 8'h00, 8'h00);
      checkAll("add_wrap_pulse_end");

      applyStimulus(1, 4'b0011, 8'h80, 8'h01);
      checkAll("sub_ovf");
      checkOutput("sub_ovf.ovf_const", 32'(ovf), 32'd1);

      applyStimulus(1, 4'b0010, 8'hFF, 8'h01);
      checkAll("b2b_add");
      applyStimulus(1, 4'b1100, 8'h10, 8'h20);
      checkAll("b2b_adc");
      checkOutput("b2b_adc.y_const", 32'(y), 32'h31);

      applyStimulus(1, 4'b1110, 8'h33, 8'h44);
      checkAll("illegal_1110");
      applyStimulus(1, 4'b1111, 8'h00, 8'h00);
      checkAll("illegal_1111");
      applyStimulus(1, 4'b0110, 8'h80, 8'h00);
      checkAll("neg_min");
      applyStimulus(1, 4'b1011, 8'h81, 8'h00);
      checkAll("asr");

`ifdef ALU_SEQ_MUL_EN
      inValid = 1'b1; op = 4'b1101; a = 8'h12; b = 8'h10;
      @(posedge clk);
      @(negedge clk);
      eOutValid = 1'b0;
      checkOutput("mul_busy0.in_ready", 32'(inReady), 32'd0);
      checkOutput("mul_busy0.out_valid", 32'(outValid), 32'd0);
      op = 4'b0000; a = 8'h77;
      for (int i = 1; i < W; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == W - 1) inValid = 1'b0;
         checkOutput($sformatf("mul_busy%0d.in_ready", i), 32'(inReady), 32'd0);
         checkOutput($sformatf("mul_busy%0d.out_valid", i), 32'(outValid), 32'd0);
      end
      @(posedge clk);
      setExpected(4'b1101, 8'h12, 8'h10);
      @(negedge clk);
      checkAll("mul_done");
      checkOutput("mul_done.y_const", 32'(y), 32'h20);
      applyStimulus(0, 4'b0000, 8'h00, 8'h00);
      checkAll("mul_pulse_end");

      inValid = 1'b1; op = 4'b1101; a = 8'hAB; b = 8'hCD;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      repeat (3) @(negedge clk);
`else
      applyStimulus(1, 4'b1101, 8'h12, 8'h10);
      checkAll("mul_disabled_illegal");
      applyStimulus(1, 4'b0101, 8'h0F, 8'hA0);
      @(negedge clk);
`endif
      #2 reset = 1'b1;
      clearExpected();
      #1;
      checkAll("reset_mid");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         checkOutput($sformatf("post_reset%0d.out_valid", i), 32'(outValid), 32'd0);
      end
      applyStimulus(1, 4'b0000, 8'h5A, 8'h00);
      checkAll("after_reset_pass");

      for (int i = 0; i < 200; i++) begin
         logic v;
         logic [3:0] o;
         v = ($urandom_range(0, 3) != 0);
         o = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_MUL_EN
         if (o == 4'd13) o = 4'd12;
`endif
         applyStimulus(v, o, 8'($urandom), 8'($urandom));
         checkAll($sformatf("rand%0d_op%0d", i, o));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
